// File: rtl/reg_read_port.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// reg_read_port
//
// Read-side port for the 7-bit dff register bank. A request carries a
// register index. The port drives a one-hot select onto the bank for one
// cycle and captures the addressed register. It then returns the value
// through a valid/ready response handshake. Indices at or above NREGS come
// back with o_rsp_err set and zero data. Only one request is outstanding at
// a time: IDLE -> SEL -> RSP -> IDLE.
//
// Optional build macro:
//   REG_READ_FWD_EN - write-to-read forwarding. If the write path writes the
//                     register being read in the SEL cycle, the response
//                     returns the newly written value. Without the macro the
//                     write-side ports are accepted but ignored.
//
// Ports:
//   i_clk          clock, all state updates on the rising edge
//   i_rst          asynchronous reset, active low
//   i_req_valid    read request present
//   o_req_ready    port can accept a request (IDLE only)
//   i_req_addr     register index to read
//   o_sel          one-hot select to the bank, zero unless in SEL
//   i_bank_rdata   flattened bank outputs, register i at [i*DW +: DW]
//   i_w_en         bank write enable   (forwarding only)
//   i_w_addr       bank write index    (forwarding only)
//   i_w_data       bank write data     (forwarding only)
//   o_rsp_valid    response held
//   i_rsp_ready    consumer accepts response
//   o_rsp_data     read result
//   o_rsp_addr     address the response belongs to
//   o_rsp_err      response was for an out-of-range address
// ---------------------------------------------------------------------------
module reg_read_port #(
  parameter int NREGS = 8,
  parameter int AW    = 4,
  parameter int DW    = 7
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_req_valid,
  output logic                o_req_ready,
  input  logic [AW-1:0]       i_req_addr,
  output logic [NREGS-1:0]    o_sel,
  input  logic [NREGS*DW-1:0] i_bank_rdata,
  input  logic                i_w_en,
  input  logic [AW-1:0]       i_w_addr,
  input  logic [DW-1:0]       i_w_data,
  output logic                o_rsp_valid,
  input  logic                i_rsp_ready,
  output logic [DW-1:0]       o_rsp_data,
  output logic [AW-1:0]       o_rsp_addr,
  output logic                o_rsp_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEL  = 2'd1,
    RSP  = 2'd2
  } state_t;

  // NREGS widened by one bit so indices up to 2^AW-1 compare correctly.
  localparam logic [AW:0] LP_NREGS = (AW+1)'(NREGS);

  state_t          r_state;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_data;
  logic            r_err;

  logic [DW-1:0]   w_slots [NREGS];
  logic [NREGS-1:0] w_sel;
  logic [DW-1:0]   w_bankData;
  logic            w_inRange;
  logic            w_fwdHit;

  assign w_inRange = ({1'b0, r_addr} < LP_NREGS);

  // Split the flattened bank bus into per-register slots. The select is
  // built only from registered state, so no path runs from i_req_addr.
  for (genvar g = 0; g < NREGS; g++) begin : g_slot
    assign w_slots[g] = i_bank_rdata[g*DW +: DW];
    assign w_sel[g]   = (r_state == SEL) && (r_addr == AW'(g));
  end

  // Read mux. It yields zero when no slot matches, so out-of-range
  // indices never reach beyond the bus.
  always_comb begin
    w_bankData = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (r_addr == AW'(i)) begin
        w_bankData = w_slots[i];
      end
    end
  end

`ifdef REG_READ_FWD_EN
  // A write to the register being read in the same cycle wins, so the
  // response matches what the bank holds after this edge.
  assign w_fwdHit = i_w_en && (i_w_addr == r_addr) && w_inRange;
`else
  logic w_unused;
  assign w_fwdHit = 1'b0;
  assign w_unused = &{1'b0, i_w_en, i_w_addr, i_w_data};
`endif

  // Main FSM. The address is captured on acceptance. The data and error
  // flag are captured at the end of SEL and held through RSP until the
  // consumer takes them.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_data  <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_req_valid) begin
            r_addr  <= i_req_addr;
            r_state <= SEL;
          end
        end
        SEL: begin
          if (w_inRange) begin
            r_data <= w_fwdHit ? i_w_data : w_bankData;
            r_err  <= 1'b0;
          end else begin
            r_data <= '0;
            r_err  <= 1'b1;
          end
          r_state <= RSP;
        end
        RSP: begin
          if (i_rsp_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_req_ready = (r_state == IDLE);
  assign o_rsp_valid = (r_state == RSP);
  assign o_sel       = w_sel;
  assign o_rsp_data  = r_data;
  assign o_rsp_addr  = r_addr;
  assign o_rsp_err   = r_err;

endmodule

// File: doc/reg_read_port.md
# reg_read_port

Read-side port for the team's bank of 7-bit `dff`-based registers. It accepts a read request carrying a register address and drives a one-hot select onto the bank. It captures the addressed register's output and returns it through a valid/ready response handshake, flagging out-of-range addresses. It sits between the CPU datapath's operand fetch and the register bank, opposite the write path that drives `chosen`/`w_en`/`w_data`.

## Interface
- `NREGS`, 8, number of registers in the bank (2..16)
- `AW`, 4, request address width; must satisfy 2^AW >= NREGS
- `DW`, 7, register data width
- `clk` in 1 — single clock; all state updates on rising edge
- `rst` in 1 — asynchronous, active-low reset (asserting low clears all state immediately)
- `req_valid` in 1 — read request present
- `req_ready` out 1 — port can accept a request
- `req_addr` in AW — register index to read
- `sel` out NREGS — one-hot register select to the bank, all-zero when idle
- `bank_rdata` in NREGS*DW — flattened register outputs; register i occupies bits [i*DW +: DW]
- `w_en` in 1 — bank write enable (used only with forwarding)
- `w_addr` in AW — bank write index (used only with forwarding)
- `w_data` in DW — bank write data (used only with forwarding)
- `rsp_valid` out 1 — response held
- `rsp_ready` in 1 — consumer accepts response
- `rsp_data` out DW — read result
- `rsp_addr` out AW — address the response belongs to
- `rsp_err` out 1 — response was for an out-of-range address

## Operation
- FSM states are IDLE, SEL and RSP; reset state is IDLE.
- IDLE:
  - `req_ready`=1 and `sel`=0.
  - On `req_valid`, latch `req_addr` and go to SEL.
- SEL (exactly one cycle):
  - `req_ready`=0.
  - If the latched addr < NREGS, `sel` is one-hot at that addr. Capture `bank_rdata` slice into `rsp_data` and clear `rsp_err`.
  - If the latched addr >= NREGS, `sel`=0. Set `rsp_data`=0 and `rsp_err`=1.
  - Then go to RSP.
- RSP:
  - `rsp_valid`=1 and `req_ready`=0.
  - `rsp_data`, `rsp_addr` and `rsp_err` are held stable until `rsp_valid & rsp_ready`.
  - On that handshake, go to IDLE.
- No back-to-back overlap: a new request is accepted only in IDLE, so at most one request is outstanding.
- Requests presented while `req_ready`=0 are ignored and do not stall anything. The requester must hold `req_valid` until it sees `req_ready`.
- `rsp_ready` held high is legal; the handshake completes on the first RSP cycle.
- Reset values: `req_ready`=1, `sel`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_addr`=0, `rsp_err`=0.
- Reset asserted mid-transaction aborts it: all state clears and no response is produced.

## Timing
- Request accepted at edge 0.
- `sel` is driven during cycle 1; data is captured at edge 1.
- `rsp_valid` is high from cycle 2.
- Minimum request-to-request spacing is 3 cycles (IDLE, SEL, RSP with immediate `rsp_ready`).
- `sel` is decoded from registered state only; there is no combinational path from `req_addr` to `sel`.
- `req_ready` and `rsp_valid` are decoded from state only; neither depends combinationally on `req_valid` or `rsp_ready`.

## Configuration
- `REG_READ_FWD_EN` defined: write-to-read forwarding.
  - Condition: in SEL, `w_en`=1, `w_addr` equals the latched addr, and addr < NREGS.
  - Effect: `rsp_data` captures `w_data` instead of `bank_rdata`. The response therefore reflects the value the bank holds after that edge.
- `REG_READ_FWD_EN` undefined:
  - `w_en`, `w_addr` and `w_data` are ignored.
  - `rsp_data` always reflects the bank contents before the concurrent write.
- Ports are identical in both builds.

## Test plan
- Reset:
  - Stimulus: hold `rst`=0, then release.
  - Required: `req_ready`=1, `rsp_valid`=0, `sel`=0, `rsp_data`=0.
- Basic read:
  - Stimulus: register 3 holds 7'h55; `req_addr`=3 with `rsp_ready`=1.
  - Required: `sel`=8'b0000_1000 in cycle 1; `rsp_valid`=1 in cycle 2 with `rsp_data`=7'h55, `rsp_addr`=3, `rsp_err`=0; IDLE in cycle 3.
- Backpressure:
  - Stimulus: `rsp_ready`=0 for 5 cycles while bank data changes.
  - Required: `rsp_data` stays 7'h55; `req_ready` stays 0; a new `req_valid` is ignored.
- Out of range:
  - Stimulus: `req_addr`=12 with NREGS=8.
  - Required: `sel` stays 0 throughout; response has `rsp_err`=1 and `rsp_data`=0.
- Forwarding:
  - Stimulus: register 2 holds 7'h11; in the SEL cycle, `w_en`=1, `w_addr`=2, `w_data`=7'h6A.
  - Required: `rsp_data`=7'h6A with `REG_READ_FWD_EN` defined, 7'h11 without it.
- Mid-operation reset:
  - Stimulus: pull `rst` low during RSP.
  - Required: `rsp_valid` drops immediately; `req_ready`=1 after release; no response is produced.
